// File: rtl/hazard_pkg.sv
// Shared hazard-control types: FSM state encoding and the hard-wired zero register.
// The forwarding logic imports the same package so both sides agree on x0 handling.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE = 2'd0,
    HZ_WAIT = 2'd1,
    HZ_ERR  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Sticks at all-ones instead of wrapping so long runs never read as small numbers.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count qualifying cycles, holding at the maximum value once reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard stall/flush controller: resolves load-use, taken-branch and data-memory
// wait hazards that forwarding cannot cover, and drives the pipeline register
// enables/clears. A memory wait freezes the whole front of the pipe, so a branch
// resolved in E during the wait is simply held and applied on the release cycle.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  hz_state_t      state;
  hz_state_t      state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;
  logic           mem_err_nxt;
  logic           lw_stall;
  logic           mem_stall;

  // Raw hazard terms; mem_stall is combinational so a miss stalls in the same cycle
  always_comb begin
    lw_stall  = MemReadE && RegWriteE && (RdE != REG_X0) &&
                ((RdE == Rs1_D) || (RdE == Rs2_D));
    mem_stall = ((state == HZ_IDLE) && MemReqM && !MemReadyM) ||
                ((state == HZ_WAIT) && !MemReadyM) ||
                (state == HZ_ERR);
  end

  // Memory-wait FSM next state, wait counter and sticky timeout flag
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      HZ_IDLE: begin
        wait_cnt_nxt = '0;
        if (MemReqM && !MemReadyM) begin
          state_nxt = HZ_WAIT;
        end
      end
      HZ_WAIT: begin
        if (MemReadyM) begin
          state_nxt    = HZ_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt    = HZ_ERR;
          wait_cnt_nxt = '0;
          mem_err_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      HZ_ERR: begin
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = HZ_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // State, wait counter and error flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HZ_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // Priority encoder: reset bubbles everything, then memory wait, branch, load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (StallF),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (FlushD),
    .q   (flush_cnt)
  );

endmodule
